// File: rtl/regfile_mp_sb.sv
// Multi-lane register file with per-register busy scoreboard for superscalar decode/writeback.
// NLANES write ports, 2*NLANES combinational read ports, optional same-cycle write->read bypass.
module regfile_mp_sb #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int NLANES      = 2,
    parameter int ZERO_REG    = 1,
    parameter int RESET_INDEX = 0,
    parameter int BYPASS      = 1
) (
    input  logic                     r_clk,
    input  logic                     r_rst,
    input  logic [NLANES-1:0]        r_wr_en,
    input  logic [NLANES*AWIDTH-1:0] r_i_addr_rd,
    input  logic [NLANES*DWIDTH-1:0] r_i_data_rd,
    input  logic [NLANES*AWIDTH-1:0] r_i_addr_rs,
    input  logic [NLANES*AWIDTH-1:0] r_i_addr_rt,
    output logic [NLANES*DWIDTH-1:0] r_o_data_rs,
    output logic [NLANES*DWIDTH-1:0] r_o_data_rt,
    input  logic [NLANES-1:0]        r_i_alloc_en,
    input  logic [NLANES*AWIDTH-1:0] r_i_alloc_addr,
    output logic [NLANES-1:0]        r_o_rs_busy,
    output logic [NLANES-1:0]        r_o_rt_busy,
    output logic                     r_o_wr_conflict
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam int NRD   = 2 * NLANES;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  alloc_hit;
    logic [DEPTH-1:0]  wr_hit;
    logic              conflict_d;

    logic [AWIDTH-1:0] wr_addr [NLANES];
    logic [DWIDTH-1:0] wr_data [NLANES];
    logic [AWIDTH-1:0] al_addr [NLANES];
    logic [NLANES-1:0] wr_eff;

    // Read ports 0..NLANES-1 are rs, NLANES..2*NLANES-1 are rt.
    logic [AWIDTH-1:0] rd_addr [NRD];
    logic [DWIDTH-1:0] rd_data [NRD];
    logic [NRD-1:0]    rd_busy;

    function automatic logic [DWIDTH-1:0] reset_value(input int idx);
        if (ZERO_REG != 0 && idx == 0) return '0;
        if (RESET_INDEX != 0) return DWIDTH'(idx);
        return '0;
    endfunction

    generate
        for (genvar g = 0; g < NLANES; g++) begin : g_lane
            assign wr_addr[g] = r_i_addr_rd[g*AWIDTH +: AWIDTH];
            assign wr_data[g] = r_i_data_rd[g*DWIDTH +: DWIDTH];
            assign al_addr[g] = r_i_alloc_addr[g*AWIDTH +: AWIDTH];
            // A write to the hardwired zero register is dropped everywhere: storage, bypass, scoreboard, conflict.
            assign wr_eff[g]  = r_wr_en[g] && !(ZERO_REG != 0 && wr_addr[g] == '0);

            assign rd_addr[g]        = r_i_addr_rs[g*AWIDTH +: AWIDTH];
            assign rd_addr[NLANES+g] = r_i_addr_rt[g*AWIDTH +: AWIDTH];

            assign r_o_data_rs[g*DWIDTH +: DWIDTH] = rd_data[g];
            assign r_o_data_rt[g*DWIDTH +: DWIDTH] = rd_data[NLANES+g];
            assign r_o_rs_busy[g]                  = rd_busy[g];
            assign r_o_rt_busy[g]                  = rd_busy[NLANES+g];
        end
    endgenerate

    // NOTE: the storage array has an async reset, so it maps to flops rather than RAM; that is what allows
    // the index-loaded test image and the instant clear when reset lands mid-stream.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= reset_value(i);
            end
        end else begin
            // Ascending lane order: the last non-blocking update wins, so the highest lane takes a collision.
            for (int k = 0; k < NLANES; k++) begin
                if (wr_eff[k]) begin
                    mem[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    // NOTE: every variable driven here gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        alloc_hit  = '0;
        wr_hit     = '0;
        conflict_d = 1'b0;
        for (int k = 0; k < NLANES; k++) begin
            if (r_i_alloc_en[k]) alloc_hit[al_addr[k]] = 1'b1;
            if (wr_eff[k])       wr_hit[wr_addr[k]]    = 1'b1;
            for (int j = k + 1; j < NLANES; j++) begin
                if (wr_eff[k] && wr_eff[j] && wr_addr[k] == wr_addr[j]) conflict_d = 1'b1;
            end
        end
    end

    // Allocation beats writeback: the new producer is younger than the one retiring.
    always_comb begin
        busy_d = alloc_hit | (busy_q & ~wr_hit);
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            busy_q          <= '0;
            r_o_wr_conflict <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            r_o_wr_conflict <= conflict_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_data[p] = mem[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NLANES; k++) begin
                    if (wr_eff[k] && wr_addr[k] == rd_addr[p]) begin
                        rd_data[p] = wr_data[k];
                        rd_busy[p] = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && rd_addr[p] == '0) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: table of hand-derived vectors fed through a scoreboard queue,
// plus hand sequences for the no-bypass variant and asynchronous reset mid-stream.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NL-1:0]     wr_en;
    logic [NL*AW-1:0]  addr_rd;
    logic [NL*DW-1:0]  data_rd;
    logic [NL*AW-1:0]  addr_rs;
    logic [NL*AW-1:0]  addr_rt;
    logic [NL-1:0]     alloc_en;
    logic [NL*AW-1:0]  alloc_addr;

    logic [NL*DW-1:0]  a_rs, a_rt, b_rs, b_rt;
    logic [NL-1:0]     a_rsb, a_rtb, b_rsb, b_rtb;
    logic              a_conf, b_conf;

    always #5 clk = ~clk;

    regfile_mp_sb #(.DWIDTH(DW), .AWIDTH(AW), .NLANES(NL), .ZERO_REG(1), .RESET_INDEX(1), .BYPASS(1)) dut (
        .r_clk(clk), .r_rst(rst), .r_wr_en(wr_en), .r_i_addr_rd(addr_rd), .r_i_data_rd(data_rd),
        .r_i_addr_rs(addr_rs), .r_i_addr_rt(addr_rt), .r_o_data_rs(a_rs), .r_o_data_rt(a_rt),
        .r_i_alloc_en(alloc_en), .r_i_alloc_addr(alloc_addr), .r_o_rs_busy(a_rsb), .r_o_rt_busy(a_rtb),
        .r_o_wr_conflict(a_conf)
    );

    regfile_mp_sb #(.DWIDTH(DW), .AWIDTH(AW), .NLANES(NL), .ZERO_REG(1), .RESET_INDEX(1), .BYPASS(0)) dut_nb (
        .r_clk(clk), .r_rst(rst), .r_wr_en(wr_en), .r_i_addr_rd(addr_rd), .r_i_data_rd(data_rd),
        .r_i_addr_rs(addr_rs), .r_i_addr_rt(addr_rt), .r_o_data_rs(b_rs), .r_o_data_rt(b_rt),
        .r_i_alloc_en(alloc_en), .r_i_alloc_addr(alloc_addr), .r_o_rs_busy(b_rsb), .r_o_rt_busy(b_rtb),
        .r_o_wr_conflict(b_conf)
    );

    typedef struct {
        logic [NL-1:0]    we;
        logic [NL*AW-1:0] wa;
        logic [NL*DW-1:0] wd;
        logic [NL-1:0]    ae;
        logic [NL*AW-1:0] aa;
        logic [NL*AW-1:0] rs;
        logic [NL*AW-1:0] rt;
        logic [NL*DW-1:0] e_rs;
        logic [NL*DW-1:0] e_rt;
        logic [NL-1:0]    e_rsb;
        logic [NL-1:0]    e_rtb;
        logic             e_conf;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t tbl [12];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] we, input logic [9:0] wa, input logic [63:0] wd,
                                input logic [1:0] ae, input logic [9:0] aa,
                                input logic [9:0] rs, input logic [9:0] rt,
                                input logic [63:0] ers, input logic [63:0] ert,
                                input logic [1:0] erb, input logic [1:0] etb, input logic ec);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ae = ae; v.aa = aa; v.rs = rs; v.rt = rt;
        v.e_rs = ers; v.e_rt = ert; v.e_rsb = erb; v.e_rtb = etb; v.e_conf = ec;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        wr_en = v.we; addr_rd = v.wa; data_rd = v.wd;
        alloc_en = v.ae; alloc_addr = v.aa;
        addr_rs = v.rs; addr_rt = v.rt;
    endtask

    task automatic idle();
        wr_en = '0; addr_rd = '0; data_rd = '0; alloc_en = '0; alloc_addr = '0;
        addr_rs = '0; addr_rt = '0;
    endtask

    // Drive one vector just after the edge, queue its expectation, compare on the falling edge.
    task automatic step(input int idx, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb_q.push_back(v);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check($sformatf("row%0d scoreboard empty", idx), 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("row%0d rs_data", idx), a_rs, e.e_rs);
            check($sformatf("row%0d rt_data", idx), a_rt, e.e_rt);
            check($sformatf("row%0d rs_busy", idx), 64'(a_rsb), 64'(e.e_rsb));
            check($sformatf("row%0d rt_busy", idx), 64'(a_rtb), 64'(e.e_rtb));
            check($sformatf("row%0d conflict", idx), 64'(a_conf), 64'(e.e_conf));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Lane 1 sits in the upper half of each packed field.
        tbl[0]  = mk(2'b00, {5'd0, 5'd0}, 64'h0, 2'b00, 10'd0, {5'd0, 5'd7}, {5'd1, 5'd31},
                     {32'd0, 32'd7}, {32'd1, 32'd31}, 2'b00, 2'b00, 1'b0);
        tbl[1]  = mk(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEAD}, 2'b00, 10'd0, {5'd5, 5'd5}, {5'd6, 5'd2},
                     {32'hDEAD, 32'hDEAD}, {32'd6, 32'd2}, 2'b00, 2'b00, 1'b0);
        tbl[2]  = mk(2'b11, {5'd9, 5'd9}, {32'h22, 32'h11}, 2'b00, 10'd0, {5'd9, 5'd9}, {5'd10, 5'd5},
                     {32'h22, 32'h22}, {32'd10, 32'hDEAD}, 2'b00, 2'b00, 1'b0);
        tbl[3]  = mk(2'b00, 10'd0, 64'h0, 2'b00, 10'd0, {5'd5, 5'd9}, {5'd3, 5'd0},
                     {32'hDEAD, 32'h22}, {32'd3, 32'd0}, 2'b00, 2'b00, 1'b1);
        tbl[4]  = mk(2'b00, 10'd0, 64'h0, 2'b01, {5'd0, 5'd3}, {5'd0, 5'd3}, {5'd0, 5'd9},
                     {32'd0, 32'd3}, {32'd0, 32'h22}, 2'b00, 2'b00, 1'b0);
        tbl[5]  = mk(2'b00, 10'd0, 64'h0, 2'b00, 10'd0, {5'd3, 5'd3}, {5'd3, 5'd4},
                     {32'd3, 32'd3}, {32'd3, 32'd4}, 2'b11, 2'b10, 1'b0);
        tbl[6]  = mk(2'b01, {5'd0, 5'd4}, {32'h0, 32'h4444}, 2'b10, {5'd4, 5'd0}, {5'd4, 5'd3}, {5'd3, 5'd4},
                     {32'h4444, 32'd3}, {32'd3, 32'h4444}, 2'b01, 2'b10, 1'b0);
        tbl[7]  = mk(2'b00, 10'd0, 64'h0, 2'b00, 10'd0, {5'd4, 5'd4}, {5'd0, 5'd3},
                     {32'h4444, 32'h4444}, {32'd0, 32'd3}, 2'b11, 2'b01, 1'b0);
        tbl[8]  = mk(2'b10, {5'd3, 5'd0}, {32'h3333, 32'h0}, 2'b00, 10'd0, {5'd3, 5'd3}, {5'd9, 5'd4},
                     {32'h3333, 32'h3333}, {32'h22, 32'h4444}, 2'b00, 2'b01, 1'b0);
        tbl[9]  = mk(2'b00, 10'd0, 64'h0, 2'b00, 10'd0, {5'd5, 5'd3}, {5'd3, 5'd4},
                     {32'hDEAD, 32'h3333}, {32'h3333, 32'h4444}, 2'b00, 2'b01, 1'b0);
        tbl[10] = mk(2'b11, {5'd0, 5'd0}, {32'hFFFF, 32'hFFFF}, 2'b01, {5'd0, 5'd0}, {5'd0, 5'd0}, {5'd0, 5'd4},
                     {32'd0, 32'd0}, {32'd0, 32'h4444}, 2'b00, 2'b01, 1'b0);
        tbl[11] = mk(2'b00, 10'd0, 64'h0, 2'b00, 10'd0, {5'd9, 5'd0}, {5'd5, 5'd4},
                     {32'h22, 32'd0}, {32'hDEAD, 32'h4444}, 2'b00, 2'b01, 1'b0);

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(i, tbl[i]);
        end

        // Bypass disabled: same-cycle write is invisible until storage updates; busy is not masked.
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b01; addr_rd = {5'd0, 5'd12}; data_rd = {32'h0, 32'hBEEF};
        alloc_en = 2'b10; alloc_addr = {5'd13, 5'd0};
        addr_rs = {5'd12, 5'd0}; addr_rt = {5'd13, 5'd0};
        @(negedge clk);
        check("bypass rs lane1", 64'(a_rs[63:32]), 64'hBEEF);
        check("nobypass rs lane1 old", 64'(b_rs[63:32]), 64'd12);
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b01; addr_rd = {5'd0, 5'd13}; data_rd = {32'h0, 32'h1313};
        addr_rs = {5'd12, 5'd0}; addr_rt = {5'd13, 5'd0};
        @(negedge clk);
        check("nobypass rs lane1 new", 64'(b_rs[63:32]), 64'hBEEF);
        check("bypass rt busy masked", 64'(a_rtb[1]), 64'd0);
        check("nobypass rt busy held", 64'(b_rtb[1]), 64'd1);
        check("bypass rt lane1 data", 64'(a_rt[63:32]), 64'h1313);
        check("nobypass rt lane1 data", 64'(b_rt[63:32]), 64'd13);
        @(posedge clk);
        #1;
        idle();
        addr_rt = {5'd13, 5'd0};
        @(negedge clk);
        check("nobypass rt busy cleared", 64'(b_rtb[1]), 64'd0);
        check("nobypass rt data stored", 64'(b_rt[63:32]), 64'h1313);

        // Async reset between edges with busy bits and conflict flag both set.
        @(posedge clk);
        #1;
        idle();
        wr_en = 2'b11; addr_rd = {5'd20, 5'd20}; data_rd = {32'hA2, 32'hA1};
        alloc_en = 2'b11; alloc_addr = {5'd8, 5'd7};
        @(posedge clk);
        #1;
        idle();
        addr_rs = {5'd20, 5'd7}; addr_rt = {5'd31, 5'd8};
        #1;
        check("pre-reset rs busy", 64'(a_rsb), 64'b01);
        check("pre-reset rt busy", 64'(a_rtb), 64'b01);
        check("pre-reset conflict", 64'(a_conf), 64'd1);
        check("pre-reset collision data", a_rs, {32'hA2, 32'd7});
        rst = 1'b1;
        #1;
        check("reset rs busy", 64'(a_rsb), 64'b00);
        check("reset rt busy", 64'(a_rtb), 64'b00);
        check("reset conflict", 64'(a_conf), 64'd0);
        check("reset rs data", a_rs, {32'd20, 32'd7});
        check("reset rt data", a_rt, {32'd31, 32'd8});
        check("reset nobypass conflict", 64'(b_conf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset conflict", 64'(a_conf), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
